// File: rtl/fifo_ctrl.sv
// fifo_ctrl: synchronous FIFO controller in front of a RegFile memory bank.
// Owns the write/read pointers and occupancy count, drives the bank's write/read
// strobes, addresses and write data, and registers the bank read data into a
// one-cycle validated output word.
//
// Parameters:
//   ws    data word width
//   depth number of entries (power of two, >= 2)
//   as    address width, derived from depth
//
// Ports:
//   clk         master clock, rising edge
//   reset       synchronous reset, active-low
//   push / din  enqueue request and data
//   pop         dequeue request
//   dout        registered dequeued word, valid while dout_valid is high
//   dout_valid  one-cycle pulse per accepted pop
//   full/empty  decoded from the registered count
//   count       occupancy, 0..depth
//   rf_wr, rf_addr_wr, rf_data_wr  bank write port (wr, AddrWr, DataIn)
//   rf_rd, rf_addr_rd, rf_data_rd  bank read port (rd, AddrRd, DataOut)
//   overflow/underflow  sticky error flags, only when FIFO_CTRL_ERR_EN is defined
//
// Optional feature macro: FIFO_CTRL_ERR_EN (adds the overflow/underflow flags).

module fifo_ctrl #(
  parameter int unsigned ws    = 4,
  parameter int unsigned depth = 8,
  localparam int unsigned as   = $clog2(depth)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [ws-1:0] din,
  input  logic          pop,
  output logic [ws-1:0] dout,
  output logic          dout_valid,
  output logic          full,
  output logic          empty,
  output logic [as:0]   count,
  output logic          rf_wr,
  output logic [as-1:0] rf_addr_wr,
  output logic [ws-1:0] rf_data_wr,
  output logic          rf_rd,
  output logic [as-1:0] rf_addr_rd,
  input  logic [ws-1:0] rf_data_rd
`ifdef FIFO_CTRL_ERR_EN
  ,
  output logic          overflow,
  output logic          underflow
`endif
);

  localparam logic [as-1:0] PtrOne   = as'(1);
  localparam logic [as:0]   CntOne   = (as+1)'(1);
  localparam logic [as:0]   CntDepth = (as+1)'(depth);

  logic [as-1:0] wptr_q, wptr_d;
  logic [as-1:0] rptr_q, rptr_d;
  logic [as:0]   count_q, count_d;
  logic [ws-1:0] dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          wr_ok, rd_ok;

  assign full  = (count_q == CntDepth);
  assign empty = (count_q == '0);

  // Gating with reset keeps the bank idle while reset is held, even before the
  // first clearing edge when the state is still unknown.
  assign wr_ok = push && !full && reset;
  assign rd_ok = pop && !empty && reset;

  assign rf_wr      = wr_ok;
  assign rf_addr_wr = wr_ok ? wptr_q : '0;
  assign rf_data_wr = wr_ok ? din : '0;
  assign rf_rd      = rd_ok;
  assign rf_addr_rd = rd_ok ? rptr_q : '0;

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    // Pointer width equals log2(depth), so the increment wraps modulo depth.
    if (wr_ok) begin
      wptr_d = wptr_q + PtrOne;
    end
    if (rd_ok) begin
      rptr_d       = rptr_q + PtrOne;
      dout_d       = rf_data_rd;
      dout_valid_d = 1'b1;
    end
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CntOne;
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign count      = count_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

`ifdef FIFO_CTRL_ERR_EN
  logic overflow_q, underflow_q;

  // A push at full is not an overflow when a pop in the same cycle is accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push && full && !rd_ok) overflow_q <= 1'b1;
      if (pop && empty) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl with a behavioural RegFile bank.
// Inputs change 1 time unit after the rising edge; combinational outputs are
// checked right after the inputs settle, registered outputs after the edge.

module tb_fifo_ctrl;

  localparam int unsigned WS    = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AS    = 3;

  logic          clk;
  logic          reset;
  logic          push;
  logic [WS-1:0] din;
  logic          pop;
  logic [WS-1:0] dout;
  logic          dout_valid;
  logic          full;
  logic          empty;
  logic [AS:0]   count;
  logic          rf_wr;
  logic [AS-1:0] rf_addr_wr;
  logic [WS-1:0] rf_data_wr;
  logic          rf_rd;
  logic [AS-1:0] rf_addr_rd;
  logic [WS-1:0] rf_data_rd;
`ifdef FIFO_CTRL_ERR_EN
  logic          overflow;
  logic          underflow;
`endif

  int tests;
  int failed;

  fifo_ctrl #(
    .ws    (WS),
    .depth (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .din        (din),
    .pop        (pop),
    .dout       (dout),
    .dout_valid (dout_valid),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .rf_wr      (rf_wr),
    .rf_addr_wr (rf_addr_wr),
    .rf_data_wr (rf_data_wr),
    .rf_rd      (rf_rd),
    .rf_addr_rd (rf_addr_rd),
    .rf_data_rd (rf_data_rd)
`ifdef FIFO_CTRL_ERR_EN
    ,
    .overflow   (overflow),
    .underflow  (underflow)
`endif
  );

  // Behavioural register-file bank: synchronous write, combinational read.
  logic [WS-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (rf_wr) mem[rf_addr_wr] <= rf_data_wr;
  end
  assign rf_data_rd = mem[rf_addr_rd];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic [WS-1:0] d, input logic q);
    push = p;
    din  = d;
    pop  = q;
    #1;
  endtask

  initial begin
    tests  = 0;
    failed = 0;

    // Reset held two cycles with both requests active.
    reset = 1'b0;
    drive(1'b1, 4'h5, 1'b1);
    for (int i = 0; i < 2; i++) begin
      check("rst_rf_wr", rf_wr, 0);
      check("rst_rf_rd", rf_rd, 0);
      check("rst_addr_wr", rf_addr_wr, 0);
      check("rst_data_wr", rf_data_wr, 0);
      tick();
    end
    check("rst_rf_wr_late", rf_wr, 0);
    reset = 1'b1;
    drive(1'b0, 4'h0, 1'b0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
`ifdef FIFO_CTRL_ERR_EN
    check("rst_overflow", overflow, 0);
    check("rst_underflow", underflow, 0);
`endif

    // Fill with 1..8.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'(i + 1), 1'b0);
      check("fill_rf_wr", rf_wr, 1);
      check("fill_addr_wr", rf_addr_wr, i);
      check("fill_data_wr", rf_data_wr, i + 1);
      tick();
      check("fill_count", count, i + 1);
    end
    check("fill_full", full, 1);
    check("fill_empty", empty, 0);

    // Push at full is dropped.
    drive(1'b1, 4'h9, 1'b0);
    check("ovf_rf_wr", rf_wr, 0);
    check("ovf_addr_wr", rf_addr_wr, 0);
    check("ovf_data_wr", rf_data_wr, 0);
    tick();
    check("ovf_count", count, 8);
`ifdef FIFO_CTRL_ERR_EN
    check("ovf_flag", overflow, 1);
    check("ovf_no_underflow", underflow, 0);
`endif

    // Drain in order.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'h0, 1'b1);
      check("drain_rf_rd", rf_rd, 1);
      check("drain_addr_rd", rf_addr_rd, i);
      tick();
      check("drain_dout", dout, i + 1);
      check("drain_valid", dout_valid, 1);
      check("drain_count", count, 7 - i);
    end
    check("drain_empty", empty, 1);

    // Pop at empty is dropped; dout holds, valid drops.
    drive(1'b0, 4'h0, 1'b1);
    check("udf_rf_rd", rf_rd, 0);
    check("udf_addr_rd", rf_addr_rd, 0);
    tick();
    check("udf_valid", dout_valid, 0);
    check("udf_dout_hold", dout, 8);
    check("udf_count", count, 0);
`ifdef FIFO_CTRL_ERR_EN
    check("udf_flag", underflow, 1);
`endif
    drive(1'b0, 4'h0, 1'b0);
    tick();

    // Wrap-around: push 6, pop 6, push 4 at addresses 6,7,0,1.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'(i + 2), 1'b0);
      tick();
    end
    check("wrap_count6", count, 6);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 4'h0, 1'b1);
      tick();
      check("wrap_pop6_dout", dout, i + 2);
    end
    check("wrap_empty", empty, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(12 + i), 1'b0);
      check("wrap_addr_wr", rf_addr_wr, (6 + i) % 8);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'h0, 1'b1);
      check("wrap_addr_rd", rf_addr_rd, (6 + i) % 8);
      tick();
      check("wrap_dout", dout, 12 + i);
      check("wrap_valid", dout_valid, 1);
    end
    drive(1'b0, 4'h0, 1'b0);
    tick();
    check("wrap_valid_drop", dout_valid, 0);

    // Simultaneous push/pop at count 3 (pointers both at 2).
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'(i + 1), 1'b0);
      tick();
    end
    drive(1'b1, 4'h4, 1'b1);
    check("pp3_rf_wr", rf_wr, 1);
    check("pp3_rf_rd", rf_rd, 1);
    check("pp3_addr_wr", rf_addr_wr, 5);
    check("pp3_addr_rd", rf_addr_rd, 2);
    tick();
    check("pp3_count", count, 3);
    check("pp3_dout", dout, 1);
    check("pp3_valid", dout_valid, 1);

    // Fill to full with 5..9, then push+pop at full.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'(i + 5), 1'b0);
      tick();
    end
    check("ppf_full", full, 1);
    drive(1'b1, 4'hF, 1'b1);
    check("ppf_rf_wr", rf_wr, 0);
    check("ppf_rf_rd", rf_rd, 1);
    tick();
    check("ppf_count", count, 7);
    check("ppf_dout", dout, 2);
    check("ppf_full_after", full, 0);
`ifdef FIFO_CTRL_ERR_EN
    check("ppf_overflow_sticky", overflow, 1);
`endif
    // Back-to-back drain of the remaining 3..9.
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 4'h0, 1'b1);
      tick();
      check("ppf_drain_dout", dout, i + 3);
      check("ppf_drain_valid", dout_valid, 1);
    end
    check("ppf_empty", empty, 1);

    // Push+pop at empty: push wins, no bypass.
    drive(1'b1, 4'hA, 1'b1);
    check("ppe_rf_wr", rf_wr, 1);
    check("ppe_rf_rd", rf_rd, 0);
    tick();
    check("ppe_count", count, 1);
    check("ppe_valid", dout_valid, 0);
    check("ppe_dout_hold", dout, 9);

    // Reset mid-stream at count 5.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(i), 1'b0);
      tick();
    end
    check("mrst_count5", count, 5);
    reset = 1'b0;
    drive(1'b0, 4'h0, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    check("mrst_count", count, 0);
    check("mrst_empty", empty, 1);
    check("mrst_dout", dout, 0);
`ifdef FIFO_CTRL_ERR_EN
    check("mrst_overflow", overflow, 0);
    check("mrst_underflow", underflow, 0);
`endif
    drive(1'b1, 4'hA, 1'b0);
    check("mrst_addr_wr", rf_addr_wr, 0);
    tick();
    drive(1'b0, 4'h0, 1'b1);
    check("mrst_addr_rd", rf_addr_rd, 0);
    tick();
    check("mrst_dout_a", dout, 4'hA);
    check("mrst_valid", dout_valid, 1);
    check("mrst_empty_end", empty, 1);
    drive(1'b0, 4'h0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Synchronous FIFO controller that turns a push/pop stream interface into the address/strobe protocol of the team's register-file memory bank (`RegFile`). It sits directly upstream of the register file: it owns the write/read pointers and the occupancy count, drives `wr`/`rd`/`AddrWr`/`AddrRd`/`DataIn` of the bank, and registers the bank's `DataOut` into a validated output word. Together the two blocks form the design's buffering FIFO.

## Interface
- `ws`, 4, data word width in bits.
- `depth`, 8, number of entries. Must be a power of two and at least 2.
- `as`, `$clog2(depth)`, address width. Derived; never overridden.

Ports (clock and reset first):
- `clk`  in  1  master clock. All state changes on the rising edge.
- `reset`  in  1  synchronous reset, active-low. Sampled on the `clk` rising edge.
- `push`  in  1  write request for `din` in the current cycle.
- `din`  in  ws  data to enqueue.
- `pop`  in  1  read request in the current cycle.
- `dout`  out  ws  dequeued word, registered.
- `dout_valid`  out  1  one-cycle pulse; `dout` is valid while this is high.
- `full`  out  1  count == depth.
- `empty`  out  1  count == 0.
- `count`  out  as+1  occupancy, 0..depth.
- `rf_wr`  out  1  to RegFile `wr`.
- `rf_addr_wr`  out  as  to RegFile `AddrWr`.
- `rf_data_wr`  out  ws  to RegFile `DataIn`.
- `rf_rd`  out  1  to RegFile `rd`.
- `rf_addr_rd`  out  as  to RegFile `AddrRd`.
- `rf_data_rd`  in  ws  from RegFile `DataOut`. Valid while `rf_rd`=1.
- `overflow`, `underflow`  out  1  sticky error flags. Present only with `FIFO_CTRL_ERR_EN`.

## Operation
- Push is accepted when `push` && !`full` && `reset`=1. The accepted push is called `wr_ok`.
- Pop is accepted when `pop` && !`empty` && `reset`=1. The accepted pop is called `rd_ok`.
- `rf_wr` = `wr_ok`, combinational. `rf_addr_wr` = `wptr` when `wr_ok`, else 0. `rf_data_wr` = `din` when `wr_ok`, else 0.
- `rf_rd` = `rd_ok`, combinational. `rf_addr_rd` = `rptr` when `rd_ok`, else 0.
- Rising edge with `wr_ok`: `wptr` <= `wptr`+1, modulo depth (depth-1 wraps to 0).
- Rising edge with `rd_ok`: `rptr` <= `rptr`+1, modulo depth; `dout` <= `rf_data_rd`; `dout_valid` <= 1.
- Rising edge without `rd_ok`: `dout_valid` <= 0 and `dout` holds its value.
- `count` update: +1 on `wr_ok` only, -1 on `rd_ok` only, unchanged on both or neither.
- `full` and `empty` are decoded from the registered `count`.
- Full with simultaneous push and pop: the pop is accepted and the push is rejected. The next count is depth-1.
- Empty with simultaneous push and pop: the push is accepted and the pop is rejected. There is no bypass, and the next count is 1.
- A rejected request has no side effect, apart from the error flags when they are enabled.

## Timing
- Reset: `reset`=0 at a rising edge clears the state. After that edge:
  - `wptr`=`rptr`=0 and `count`=0.
  - `empty`=1 and `full`=0.
  - `dout`=0 and `dout_valid`=0.
  - error flags = 0.
- While `reset`=0, `rf_wr` and `rf_rd` are forced to 0 and the address/data outputs are 0. No bank access occurs during reset.
- Reset mid-operation discards all stored entries. The bank contents are not cleared, but they become unreachable.
- Write latency: data is in the bank at the edge closing the `wr_ok` cycle. The same word can be popped no earlier than the next cycle, when `empty` first deasserts.
- Read latency: `pop` in cycle N gives `dout`/`dout_valid` after edge N, for exactly one cycle per accepted pop.
- Back-to-back pops stream one word per cycle.
- `full`, `empty` and `count` update at the edge that commits the change. Requesters sample them combinationally in the same cycle they drive `push`/`pop`.

## Configuration
- `FIFO_CTRL_ERR_EN` defined:
  - `overflow` sets on `push` && `full` && !`rd_ok`.
  - `underflow` sets on `pop` && `empty`.
  - Both are sticky until reset.
- `FIFO_CTRL_ERR_EN` undefined: the ports and logic are absent. Rejected requests are silently dropped.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `push`=`pop`=1 -> `rf_wr`=`rf_rd`=0 throughout; after release `empty`=1, `count`=0, `dout`=0, `dout_valid`=0.
- Fill: 8 pushes of 0x1..0x8 -> `rf_addr_wr` steps 0..7, `full`=1 after the 8th. A 9th push of 0x9 gives `rf_wr`=0, `count` stays 8, and `overflow`=1 with the macro enabled.
- Drain: 8 pops -> `dout` = 0x1..0x8 in order, each with a one-cycle `dout_valid`; `empty`=1 after the last. An extra pop gives `rf_rd`=0 and `underflow`=1 with the macro enabled.
- Wrap-around: push 6, pop 6, push 4 -> the write addresses are 6, 7, 0, 1; popping returns those 4 words in order.
- Simultaneous push and pop:
  - At count 3: count stays 3, both bank strobes are high in the same cycle.
  - At full: count becomes 7.
  - At empty: count becomes 1 and `dout_valid` stays 0.
- Reset mid-stream: at count 5, pulse `reset`=0 for 1 cycle -> `count`=0 and `empty`=1. A following push of 0xA then pop returns 0xA from address 0.
